// File: rtl/laser_clk_sequencer.sv
// laser_clk_sequencer
//
// Consumer end of the Laser500 PLL, clocked by the 117.582417 MHz master clock.
// Synchronizes the PLL locked flag, waits for it to stay stable before
// releasing the core reset, then produces phase-aligned single-cycle clock
// enables at /DIV_VID, /DIV_PIX and /DIV_CPU. Loss of lock re-asserts the core
// reset for at least HOLD_CYCLES cycles and stops the enables.
//
// Optional feature (macro LASER_CLKSEQ_LOSS_CNT_EN):
//   defined   - lock_loss_cnt is a saturating count of lock-loss events.
//   undefined - no counter is built and lock_loss_cnt is tied to 8'h00.
//
// Ports:
//   clk           in   master clock
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL locked flag, asynchronous to clk
//   sys_rst_n     out  core reset, active-low, deasserted synchronously
//   ce_vid        out  one-cycle enable every DIV_VID cycles
//   ce_pix        out  one-cycle enable every DIV_PIX cycles
//   ce_cpu        out  one-cycle enable every DIV_CPU cycles
//   running       out  high while in RUN
//   lock_loss_cnt out  saturating lock-loss event count (8 bits)

module laser_clk_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES        = 16,
    parameter int unsigned DIV_VID            = 4,
    parameter int unsigned DIV_PIX            = 8,
    parameter int unsigned DIV_CPU            = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       sys_rst_n,
    output logic       ce_vid,
    output logic       ce_pix,
    output logic       ce_cpu,
    output logic       running,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned DIV_W  = (DIV_CPU > 1) ? $clog2(DIV_CPU) : 1;
    localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Divisors are powers of two, so "div_cnt mod DIV" is a mask.
    localparam logic [DIV_W-1:0] VID_MASK = DIV_W'(DIV_VID - 1);
    localparam logic [DIV_W-1:0] PIX_MASK = DIV_W'(DIV_PIX - 1);
    localparam logic [DIV_W-1:0] CPU_MASK = DIV_W'(DIV_CPU - 1);

    typedef enum logic [1:0] {
        StWait = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;

    logic sys_rst_n_d, running_d, ce_vid_d, ce_pix_d, ce_cpu_d;
    logic loss_evt;

    // ------------------------------------------------------------------
    // pll_locked synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StWait;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            div_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWait: if (locked_s && stab_cnt_q == STAB_LAST) state_d = StRun;
            StRun:  if (!locked_s) state_d = StHold;
            StHold: if (hold_cnt_q == HOLD_LAST) state_d = StWait;
            default: state_d = StWait;
        endcase
    end

    // Each counter runs only while its state persists and is zero otherwise,
    // so every state is entered with its counter already cleared.
    always_comb begin
        stab_cnt_d = '0;
        hold_cnt_d = '0;
        div_cnt_d  = '0;
        case (state_q)
            StWait: if (state_d == StWait && locked_s) stab_cnt_d = stab_cnt_q + 1'b1;
            StRun:  if (state_d == StRun) div_cnt_d = div_cnt_q + 1'b1;
            StHold: if (state_d == StHold) hold_cnt_d = hold_cnt_q + 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (computed from the next state, then registered)
    // ------------------------------------------------------------------
    // Strobes are derived from div_cnt_d so each registered pulse lines up
    // with the cycle in which div_cnt_q holds the matching value. Leaving RUN
    // forces them low on that same edge.
    always_comb begin
        sys_rst_n_d = (state_d == StRun);
        running_d   = (state_d == StRun);
        ce_vid_d    = (state_d == StRun) && ((div_cnt_d & VID_MASK) == VID_MASK);
        ce_pix_d    = (state_d == StRun) && ((div_cnt_d & PIX_MASK) == PIX_MASK);
        ce_cpu_d    = (state_d == StRun) && ((div_cnt_d & CPU_MASK) == CPU_MASK);
        loss_evt    = (state_q == StRun) && (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n <= 1'b0;
            running   <= 1'b0;
            ce_vid    <= 1'b0;
            ce_pix    <= 1'b0;
            ce_cpu    <= 1'b0;
        end else begin
            sys_rst_n <= sys_rst_n_d;
            running   <= running_d;
            ce_vid    <= ce_vid_d;
            ce_pix    <= ce_pix_d;
            ce_cpu    <= ce_cpu_d;
        end
    end

    // ------------------------------------------------------------------
    // Lock-loss event counter
    // ------------------------------------------------------------------
`ifdef LASER_CLKSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'h00;
        end else if (loss_evt && loss_cnt_q != 8'hff) begin
            loss_cnt_q <= loss_cnt_q + 8'h01;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic unused_loss_evt;
    assign unused_loss_evt = loss_evt;
    assign lock_loss_cnt   = 8'h00;
`endif

endmodule
